// File: rtl/arisco_pkg.sv
// Shared decode constants, FSM states and ALU operation codes
// for the multi-cycle instruction sequencer.
package arisco_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WB
  } seq_state_t;

  typedef enum logic [2:0] {
    ALU_NOP,
    ALU_ADDI,
    ALU_XORI,
    ALU_ORI,
    ALU_ANDI,
    ALU_ADD,
    ALU_SUB,
    ALU_LUI
  } alu_op_t;

  function automatic logic [31:0] sext12(
    input logic [11:0] v
  );
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/seq_alu.sv
// Combinational result unit for the sequencer's integer subset.
// All arithmetic wraps modulo 2^32.
module seq_alu
  import arisco_pkg::*;
(
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] imm,
  input  alu_op_t     alu_op,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    unique case (alu_op)
      ALU_ADDI: result = op_a + imm;
      ALU_XORI: result = op_a ^ imm;
      ALU_ORI:  result = op_a | imm;
      ALU_ANDI: result = op_a & imm;
      ALU_ADD:  result = op_a + op_b;
      ALU_SUB:  result = op_a - op_b;
      ALU_LUI:  result = imm;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Four-state controller: accept, read operands, execute,
// write back to the external register file.
module instr_sequencer
  import arisco_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instruction,
  output logic [4:0]       rd_address_a,
  output logic [4:0]       rd_address_b,
  input  logic [31:0]      data_out_a,
  input  logic [31:0]      data_out_b,
  output logic             wr_enable,
  output logic [4:0]       wr_address,
  output logic [31:0]      wr_data,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_count
);

  seq_state_t state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] res_q, res_d;
  logic        ill_q, ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  alu_op_t     alu_op;
  logic        dec_ill;
  logic [31:0] imm;
  logic [31:0] alu_res;
  logic        in_wb;

  assign opc = ir_q[6:0];
  assign f3  = ir_q[14:12];
  assign f7  = ir_q[31:25];

  always_comb begin
    alu_op  = ALU_NOP;
    dec_ill = 1'b1;
    imm     = sext12(ir_q[31:20]);
    unique case (1'b1)
      opc == OPC_OP_IMM: begin
        dec_ill = 1'b0;
        case (f3)
          F3_ADD:  alu_op = ALU_ADDI;
          F3_XOR:  alu_op = ALU_XORI;
          F3_OR:   alu_op = ALU_ORI;
          F3_AND:  alu_op = ALU_ANDI;
          default: dec_ill = 1'b1;
        endcase
      end
      opc == OPC_OP && f3 == F3_ADD
        && f7 == F7_BASE: begin
        alu_op  = ALU_ADD;
        dec_ill = 1'b0;
      end
      opc == OPC_OP && f3 == F3_ADD
        && f7 == F7_SUB: begin
        alu_op  = ALU_SUB;
        dec_ill = 1'b0;
      end
      opc == OPC_LUI: begin
        alu_op  = ALU_LUI;
        dec_ill = 1'b0;
        imm     = {ir_q[31:12], 12'b0};
      end
      default: ;
    endcase
  end

  seq_alu u_alu (
    .op_a   (op_a_q),
    .op_b   (op_b_q),
    .imm    (imm),
    .alu_op (alu_op),
    .result (alu_res)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (instr_valid) begin
          ir_d    = instruction;
          state_d = READ;
        end
      end
      READ: begin
        op_a_d  = data_out_a;
        op_b_d  = data_out_b;
        state_d = EXEC;
      end
      EXEC: begin
        res_d   = alu_res;
        ill_d   = dec_ill;
        state_d = WB;
      end
      WB: begin
        // x0 targets still retire; only the write is dropped
        if (!ill_q) cnt_d = cnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ir_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_wb         = state_q == WB;
  assign instr_ready   = (state_q == IDLE) && !rst;
  assign busy          = state_q != IDLE;
  assign done          = in_wb;
  assign illegal       = in_wb && ill_q;
  assign wr_enable     = in_wb && !ill_q
                         && (ir_q[11:7] != 5'd0);
  assign wr_address    = in_wb ? ir_q[11:7] : 5'd0;
  assign wr_data       = in_wb ? res_q : 32'd0;
  assign rd_address_a  = ir_q[19:15];
  assign rd_address_b  = ir_q[24:20];
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench: directed and random instructions against
// an architectural model of the integer subset and a register file.
module tb_instr_sequencer;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             instr_valid = 1'b0;
  logic             instr_ready;
  logic [31:0]      instruction = 32'd0;
  logic [4:0]       rd_address_a;
  logic [4:0]       rd_address_b;
  logic [31:0]      data_out_a;
  logic [31:0]      data_out_b;
  logic             wr_enable;
  logic [4:0]       wr_address;
  logic [31:0]      wr_data;
  logic             busy;
  logic             done;
  logic             illegal;
  logic [CNT_W-1:0] retired_count;

  instr_sequencer #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instruction   (instruction),
    .rd_address_a  (rd_address_a),
    .rd_address_b  (rd_address_b),
    .data_out_a    (data_out_a),
    .data_out_b    (data_out_b),
    .wr_enable     (wr_enable),
    .wr_address    (wr_address),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done),
    .illegal       (illegal),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  // register file the DUT drives
  logic [31:0] rf [32] = '{default: 32'd0};
  assign data_out_a = (rd_address_a == 5'd0) ? 32'd0 : rf[rd_address_a];
  assign data_out_b = (rd_address_b == 5'd0) ? 32'd0 : rf[rd_address_b];
  always @(posedge clk)
    if (wr_enable && wr_address != 5'd0) rf[wr_address] <= wr_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic             we;
    logic [4:0]       rd;
    logic [31:0]      data;
    logic             ill;
    logic [CNT_W-1:0] cnt;
    int               wb_cyc;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mdl [32];
  int          mdl_cnt = 0;
  int          tests = 0;
  int          fails = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // architectural model: effect of one instruction
  function automatic void ref_exec(input logic [31:0] ins, input int at);
    exp_t e;
    logic [31:0] a, b, imm, r;
    logic ok;
    a   = mdl[ins[19:15]];
    b   = mdl[ins[24:20]];
    imm = 32'($signed(ins[31:20]));
    r   = 32'd0;
    ok  = 1'b1;
    if (ins[6:0] == 7'h13) begin
      case (ins[14:12])
        3'd0: r = a + imm;
        3'd4: r = a ^ imm;
        3'd6: r = a | imm;
        3'd7: r = a & imm;
        default: ok = 1'b0;
      endcase
    end else if (ins[6:0] == 7'h33 && ins[14:12] == 3'd0
                 && ins[31:25] == 7'h00) r = a + b;
    else if (ins[6:0] == 7'h33 && ins[14:12] == 3'd0
             && ins[31:25] == 7'h20) r = a - b;
    else if (ins[6:0] == 7'h37) r = ins & 32'hFFFFF000;
    else ok = 1'b0;
    if (ok) begin
      mdl_cnt = (mdl_cnt + 1) % (1 << CNT_W);
      if (ins[11:7] != 5'd0) mdl[ins[11:7]] = r;
    end
    e.we     = ok && ins[11:7] != 5'd0;
    e.rd     = ins[11:7];
    e.data   = r;
    e.ill    = !ok;
    e.cnt    = CNT_W'(mdl_cnt);
    e.wb_cyc = at + 3;
    sb.push_back(e);
  endfunction

  // called at a negedge; returns at the negedge after the accept edge
  task automatic issue(input logic [31:0] ins, input bit keep,
                       input bit push, output int acc);
    int n;
    instruction = ins;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (!instr_ready) begin
      chk("accept_timeout", 32'(instr_ready), 32'd1);
    end else if (push) begin
      ref_exec(ins, cyc);
    end
    @(negedge clk);
    if (!keep) instr_valid = 1'b0;
  endtask

  // monitor
  bit               cnt_chk = 0;
  logic [CNT_W-1:0] cnt_exp;
  always @(negedge clk) begin
    exp_t e;
    if (cnt_chk) begin
      chk("retired_count", 32'(retired_count), 32'(cnt_exp));
      cnt_chk = 0;
    end
    if (!rst) chk("ready_vs_busy", 32'(instr_ready), 32'(!busy));
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wb_cycle", cyc, e.wb_cyc);
        chk("wr_enable", 32'(wr_enable), 32'(e.we));
        chk("wr_address", 32'(wr_address), 32'(e.rd));
        chk("illegal", 32'(illegal), 32'(e.ill));
        if (e.we) chk("wr_data", wr_data, e.data);
        cnt_exp = e.cnt;
        cnt_chk = 1;
      end
    end else begin
      chk("idle_wr_enable", 32'(wr_enable), 32'd0);
      chk("idle_illegal", 32'(illegal), 32'd0);
    end
  end

  function automatic logic [31:0] rnd_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] im;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    im  = 12'($urandom);
    case ($urandom_range(0, 9))
      0: return {im, rs1, 3'd0, rd, 7'h13};
      1: return {im, rs1, 3'd4, rd, 7'h13};
      2: return {im, rs1, 3'd6, rd, 7'h13};
      3: return {im, rs1, 3'd7, rd, 7'h13};
      4: return {7'h00, rs2, rs1, 3'd0, rd, 7'h33};
      5: return {7'h20, rs2, rs1, 3'd0, rd, 7'h33};
      6: return {20'($urandom), rd, 7'h37};
      7: return {im, rs1, 3'd1, rd, 7'h13};
      8: return {7'h01, rs2, rs1, 3'd0, rd, 7'h33};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int a0, a1, a2, t;
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr_enable", 32'(wr_enable), 32'd0);
    chk("rst_wr_address", 32'(wr_address), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_count", 32'(retired_count), 32'd0);
    chk("rst_rd_addr_a", 32'(rd_address_a), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(instr_ready), 32'd1);

    issue(32'h00500093, 0, 1, t);
    issue(32'hFFD00113, 0, 1, t);
    issue(32'h002081B3, 0, 1, t);
    issue(32'h40208233, 0, 1, t);
    issue(32'hABCDE2B7, 0, 1, t);
    issue(32'h1232E293, 0, 1, t);
    issue(32'h00700013, 0, 1, t);
    issue(32'h00000073, 0, 1, t);
    repeat (6) @(negedge clk);
    chk("x1", rf[1], 32'd5);
    chk("x2", rf[2], 32'hFFFFFFFD);
    chk("x3", rf[3], 32'd2);
    chk("x4", rf[4], 32'd8);
    chk("x5", rf[5], 32'hABCDE123);
    chk("count_directed", 32'(retired_count), 32'd7);

    issue(32'h00100313, 1, 1, a0);
    issue(32'h00230393, 1, 1, a1);
    issue(32'h00338413, 0, 1, a2);
    chk("stream_gap1", a1 - a0, 32'd4);
    chk("stream_gap2", a2 - a1, 32'd4);
    repeat (6) @(negedge clk);

    // abort during EXEC: no write, counter cleared
    issue(32'h00900313, 0, 0, t);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready_in_rst", 32'(instr_ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    mdl_cnt = 0;
    @(negedge clk);
    chk("abort_ready", 32'(instr_ready), 32'd1);
    chk("abort_busy_after", 32'(busy), 32'd0);
    chk("abort_count", 32'(retired_count), 32'd0);
    chk("abort_x6", rf[6], mdl[6]);

    for (int i = 0; i < 200; i++) begin
      issue(rnd_instr(), $urandom_range(0, 1), 1, t);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    instr_valid = 1'b0;
    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain", sb.size(), 32'd0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 32; i++) chk("regfile", rf[i], mdl[i]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle controller that accepts one 32-bit RV32I instruction at a time over a valid/ready handshake and sequences the register_memory through read, execute and write-back. It drives the register file's two read addresses and its write port, and computes results for a small integer subset. It sits between the instruction source and register_memory, replacing direct instruction-field wiring.

Parameters:
CNT_W, 16, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
instr_valid  input  1  instruction presented
instr_ready  output  1  sequencer can accept an instruction
instruction  input  32  RV32I instruction word
rd_address_a  output  5  register_memory read port A address (rs1)
rd_address_b  output  5  register_memory read port B address (rs2)
data_out_a  input  32  register_memory read data A (combinational from rd_address_a)
data_out_b  input  32  register_memory read data B (combinational from rd_address_b)
wr_enable  output  1  register_memory write strobe
wr_address  output  5  register_memory write address (rd)
wr_data  output  32  register_memory write data
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse in WB, legal or illegal instruction
illegal  output  1  one-cycle pulse with done when instruction unsupported
retired_count  output  CNT_W  count of legal instructions written back

Behaviour:
Clock is clk; reset is synchronous, active-high, named rst. Regfile reads are combinational; writes commit on the clk edge while wr_enable=1.
States IDLE -> READ -> EXEC -> WB -> IDLE, unconditional except for IDLE.
IDLE: instr_ready=1. On instr_valid=1, latch instruction into ir and go to READ. instr_ready=0 in all other states, so no backpressure ambiguity.
READ: rd_address_a=ir[19:15], rd_address_b=ir[24:20]; latch data_out_a/b into op_a/op_b at the end of the cycle. The addresses hold these values in every state; they are 0 after reset until the first accept.
EXEC: decode ir and compute result; latch result and an illegal flag.
WB: wr_address=ir[11:7], wr_data=result. wr_enable=1 only if the instruction is legal and rd!=0 (x0 writes suppressed). done=1. illegal=flag. retired_count increments if legal, including when rd=0.
Latency: accept edge at cycle 0 leads to WB in cycle 3. One instruction per 4 cycles max.
Supported operations. Immediate is sign-extended ir[31:20]. All arithmetic is 32-bit modulo with no overflow flag.
  opcode 0010011: funct3 000 ADDI, 100 XORI, 110 ORI, 111 ANDI.
  opcode 0110011 with funct3 000: funct7 0000000 ADD, 0100000 SUB.
  opcode 0110111: LUI, result = {ir[31:12], 12'b0}.
  Anything else is illegal: no write, no count, illegal=1 with done.
Read-after-write: the next instruction's READ occurs after the previous WB edge, so it sees updated values. No forwarding is needed.
Reset values: instr_ready=0 during the reset cycle, then 1 in IDLE. busy=0, done=0, illegal=0, wr_enable=0, wr_address=0, wr_data=0, retired_count=0, ir=0.
Reset mid-operation: abort, go to IDLE, issue no write, discard ir. rst dominates instr_valid in the same cycle.
retired_count wraps from all-ones to 0.
Outputs not listed as active in a state are 0 there: wr_enable, done, illegal.

Decomposition:
Shared package arisco_pkg holds:
  opcode constants OPC_OP_IMM, OPC_OP, OPC_LUI;
  funct3 constants F3_ADD, F3_XOR, F3_OR, F3_AND;
  funct7 constants F7_BASE, F7_SUB;
  state enum seq_state_t {IDLE, READ, EXEC, WB};
  ALU op enum alu_op_t.
One natural sub-module is seq_alu: combinational, takes op_a, op_b, imm, alu_op and returns result. Decode and FSM stay in instr_sequencer.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093) with instr_valid held one cycle. Expect wr_enable=1, wr_address=1, wr_data=5 exactly 3 cycles after accept; done=1; retired_count=1.
- After x1=5, ADDI x2,x0,-3 (0xFFD00113) then ADD x3,x1,x2 (0x002081B3). Expect x2=0xFFFFFFFD, x3=2. Then SUB x4,x1,x2 (0x40208233) gives x4=8.
- LUI x5,0xABCDE (0xABCDE2B7). Expect wr_data=0xABCDE000. Then ORI x5,x5,0x123 gives 0xABCDE123.
- ADDI x0,x0,7 (0x00700013): expect wr_enable=0 in WB, done=1, retired_count increments. Then unsupported word 0x00000073: expect illegal=1, done=1, no write, count unchanged.
- Hold instr_valid high continuously with a stream of 3 instructions. Expect instr_ready high only in IDLE and accepts spaced exactly 4 cycles apart.
- Assert rst in EXEC of ADDI x6,x0,9. Expect no write to x6, busy=0 and instr_ready=1 on the cycle after rst deasserts, and retired_count=0.
